// File: rtl/lvds_pkg.sv
// lvds_pkg: shared RX alignment states and TX source selectors for lvds_link
package lvds_pkg;
  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} rx_state_t;
  localparam logic [1:0] TXM_LOOP  = 2'b00;
  localparam logic [1:0] TXM_TRAIN = 2'b01;
  localparam logic [1:0] TXM_IDLE  = 2'b10;
  localparam logic [1:0] TXM_CNT   = 2'b11;
endpackage

// File: rtl/lvds_lane_align.sv
// lvds_lane_align: one RX lane -- deserialiser plus sliding word-boundary alignment
// clk/rst: clock, async active-high reset; din: serial bit (LSB-first words)
// train_en: allows FSM advance and slips; word: last boundary word
// valid: one-cycle pulse per word while locked; locked: lane is aligned
module lvds_lane_align
  import lvds_pkg::*;
#(
  parameter int                WORD_W    = 8,
  parameter logic [WORD_W-1:0] TRAIN_PAT = 8'hA5,
  parameter int                LOCK_CNT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              train_en,
  output logic [WORD_W-1:0] word,
  output logic              valid,
  output logic              locked
);
  localparam int CW = $clog2(WORD_W);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);
  localparam logic [MW-1:0] LC = MW'(LOCK_CNT);
  logic [WORD_W-1:0] sr;
  logic [CW-1:0] cnt;
  logic [MW-1:0] mcnt;
  rx_state_t state;
  logic [WORD_W-1:0] cand;
  logic bnd, match, slip;
  assign cand  = {din, sr[WORD_W-1:1]};
  assign bnd   = cnt == LAST;
  assign match = cand == TRAIN_PAT;
  // a slip holds the counter at the boundary so the next window is one bit later
  assign slip  = bnd && train_en && !match;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr     <= '0;
      cnt    <= '0;
      mcnt   <= '0;
      state  <= HUNT;
      word   <= '0;
      valid  <= 1'b0;
      locked <= 1'b0;
    end else begin
      sr    <= cand;
      cnt   <= slip ? cnt : (bnd ? '0 : cnt + 1'b1);
      valid <= 1'b0;
      if (bnd) begin
        word  <= cand;
        valid <= state == LOCKED;
        if (train_en) begin
          case (state)
            HUNT: if (match) begin
              state <= CONFIRM;
              mcnt  <= MW'(1);
            end
            CONFIRM: if (match) begin
              mcnt <= mcnt + 1'b1;
              if (mcnt + 1'b1 == LC) begin
                state  <= LOCKED;
                valid  <= 1'b1;
                locked <= 1'b1;
              end
            end else begin
              state <= HUNT;
              mcnt  <= '0;
            end
            LOCKED: if (!match) begin
              state  <= HUNT;
              mcnt   <= '0;
              valid  <= 1'b0;
              locked <= 1'b0;
            end
            default: state <= HUNT;
          endcase
        end
      end
    end
  end
endmodule

// File: rtl/lvds_link.sv
// lvds_link: multi-lane LVDS link engine -- per-lane RX alignment and shared TX word source
// clk/rst: clock, async active-high reset; lane_in: serial RX bits
// train_en: alignment enable; tx_mode: 00 loop, 01 train, 10 idle, 11 counter
// rx_word: lane c at [c*WORD_W +: WORD_W]; rx_valid/locked: per-lane status
// lane_out: registered serial TX bits
module lvds_link
  import lvds_pkg::*;
#(
  parameter int                CHANNELS  = 4,
  parameter int                WORD_W    = 8,
  parameter logic [WORD_W-1:0] TRAIN_PAT = 8'hA5,
  parameter int                LOCK_CNT  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS-1:0]        lane_in,
  input  logic                       train_en,
  input  logic [1:0]                 tx_mode,
  output logic [CHANNELS*WORD_W-1:0] rx_word,
  output logic [CHANNELS-1:0]        rx_valid,
  output logic [CHANNELS-1:0]        locked,
  output logic [CHANNELS-1:0]        lane_out
);
  localparam int CW = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    lvds_lane_align #(
      .WORD_W   (WORD_W),
      .TRAIN_PAT(TRAIN_PAT),
      .LOCK_CNT (LOCK_CNT)
    ) u_align (
      .clk     (clk),
      .rst     (rst),
      .din     (lane_in[c]),
      .train_en(train_en),
      .word    (rx_word[c*WORD_W +: WORD_W]),
      .valid   (rx_valid[c]),
      .locked  (locked[c])
    );
  end
  logic [CW-1:0] tcnt;
  logic [1:0] mode_q;
  logic [WORD_W-1:0] ctr;
  logic pat_bit;
  assign pat_bit = mode_q == TXM_TRAIN ? TRAIN_PAT[tcnt] : ctr[tcnt];
  // mode and counter only change at the last bit so every TX word is sent whole
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt     <= '0;
      mode_q   <= TXM_LOOP;
      ctr      <= '0;
      lane_out <= '0;
    end else begin
      tcnt <= tcnt == LAST ? '0 : tcnt + 1'b1;
      if (tcnt == LAST) begin
        mode_q <= tx_mode;
        if (mode_q == TXM_CNT) ctr <= ctr + 1'b1;
      end
      lane_out <= mode_q == TXM_LOOP ? lane_in : mode_q == TXM_IDLE ? '0 : {CHANNELS{pat_bit}};
    end
  end
endmodule

// File: tb/tb_lvds_link.sv
// tb_lvds_link: directed, table-driven self-checking bench for lvds_link
module tb_lvds_link;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] lane_in = '0;
  logic train_en = 1'b0;
  logic [1:0] tx_mode = 2'b00;
  logic [31:0] rx_word;
  logic [3:0] rx_valid, locked, lane_out;
  int n_chk = 0;
  int n_fail = 0;
  int ecnt;
  logic [7:0] pat = 8'hA5;

  lvds_link #(.CHANNELS(4), .WORD_W(8), .TRAIN_PAT(8'hA5), .LOCK_CNT(4)) dut (
    .clk(clk), .rst(rst), .lane_in(lane_in), .train_en(train_en), .tx_mode(tx_mode),
    .rx_word(rx_word), .rx_valid(rx_valid), .locked(locked), .lane_out(lane_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) ecnt <= 0;
    else ecnt <= ecnt + 1;

  typedef struct packed {
    logic te;
    logic [7:0] w;
    logic [7:0] ew;
    logic ev;
    logic el;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] sbits(input int k, input bit stagger);
    logic [3:0] s;
    for (int c = 0; c < 4; c++) begin
      int o;
      o = stagger ? c : 0;
      s[c] = (k <= o) ? 1'b0 : pat[(k - o - 1) % 8];
    end
    return s;
  endfunction

  initial begin
    int lock_at [4];
    logic [7:0] wat [4];
    logic vat [4];
    logic bad;
    logic prev_l;
    logic [3:0] v;
    logic [7:0] trb;
    logic [7:0] cw;
    tbl[0] = '{1'b0, 8'h3C, 8'h3C, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 8'h3C, 8'h3C, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 8'hA5, 8'hA5, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 8'hA4, 8'hA4, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 8'hA5, 8'hA5, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 8'h3C, 8'h3C, 1'b1, 1'b1};
    trb = 8'b1010_0101;

    // reset state
    tick();
    tick();
    check("rst_rx_word", rx_word, 32'h0);
    check("rst_rx_valid", {28'h0, rx_valid}, 32'h0);
    check("rst_locked", {28'h0, locked}, 32'h0);
    check("rst_lane_out", {28'h0, lane_out}, 32'h0);
    rst = 1'b0;

    // hold in HUNT: pattern present but train_en=0, no slips
    bad = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      lane_in = sbits(k, 1'b1);
      tick();
      if (locked !== 4'h0 || rx_valid !== 4'h0) bad = 1'b1;
      if (k == 8) check("hold_word_e8", rx_word, 32'h28944AA5);
      if (k == 9) check("hold_word_e9", rx_word, 32'h28944AA5);
      if (k == 16) check("hold_word_e16", rx_word, 32'h2D964BA5);
    end
    check("hold_no_lock", {31'h0, bad}, 32'h0);

    // alignment: lane c offset by c bits, training TX active
    rst = 1'b1;
    train_en = 1'b1;
    tx_mode = 2'b01;
    #2;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) lock_at[c] = 0;
    for (int k = 1; k <= 62; k++) begin
      lane_in = sbits(k, 1'b1);
      tick();
      for (int c = 0; c < 4; c++)
        if (lock_at[c] == 0 && locked[c]) begin
          lock_at[c] = k;
          wat[c] = rx_word[c*8 +: 8];
          vat[c] = rx_valid[c];
        end
    end
    for (int c = 0; c < 4; c++) begin
      check($sformatf("lock_edge_l%0d", c), lock_at[c], 32 + c);
      check($sformatf("lock_within_l%0d", c), {31'h0, (lock_at[c] - c) <= 39}, 32'h1);
      check($sformatf("lock_word_l%0d", c), {24'h0, wat[c]}, 32'hA5);
      check($sformatf("lock_valid_l%0d", c), {31'h0, vat[c]}, 32'h1);
    end
    check("lock_all", {28'h0, locked}, 32'hF);
    check("train_bit5", {28'h0, lane_out}, 32'hF);

    // async reset mid-cycle while locked and training
    #3;
    rst = 1'b1;
    #1;
    check("arst_rx_word", rx_word, 32'h0);
    check("arst_rx_valid", {28'h0, rx_valid}, 32'h0);
    check("arst_locked", {28'h0, locked}, 32'h0);
    check("arst_lane_out", {28'h0, lane_out}, 32'h0);
    tx_mode = 2'b00;
    #1;
    rst = 1'b0;
    lane_in = sbits(1, 1'b0);
    tick();
    check("arst_loopback", {28'h0, lane_out}, 32'hF);
    for (int k = 2; k <= 32; k++) begin
      lane_in = sbits(k, 1'b0);
      tick();
      if (k == 31) check("relock_e31", {28'h0, locked}, 32'h0);
      if (k == 32) check("relock_e32", {28'h0, locked}, 32'hF);
      if (k == 32) check("relock_valid", {28'h0, rx_valid}, 32'hF);
    end

    // data after lock, loss of lock and relock
    prev_l = 1'b1;
    for (int n = 0; n < 10; n++) begin
      train_en = tbl[n].te;
      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
        lane_in = {4{tbl[n].w[i]}};
        tick();
        if (i < 7 && (rx_valid !== 4'h0 || locked !== {4{prev_l}})) bad = 1'b1;
      end
      check($sformatf("vec%0d_mid", n), {31'h0, bad}, 32'h0);
      check($sformatf("vec%0d_word", n), rx_word, {4{tbl[n].ew}});
      check($sformatf("vec%0d_valid", n), {28'h0, rx_valid}, {28'h0, {4{tbl[n].ev}}});
      check($sformatf("vec%0d_locked", n), {28'h0, locked}, {28'h0, {4{tbl[n].el}}});
      prev_l = tbl[n].el;
    end

    // TX modes
    train_en = 1'b0;
    for (int g = 0; g < 8 && (ecnt % 8) != 0; g++) begin
      lane_in = 4'($urandom);
      tick();
    end
    check("tx_word_phase", ecnt % 8, 0);
    tx_mode = 2'b01;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = 4'($urandom);
      lane_in = v;
      tick();
      if (lane_out !== v) bad = 1'b1;
    end
    check("tx_loop_word", {31'h0, bad}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      lane_in = 4'($urandom);
      if (i == 3) tx_mode = 2'b11;
      tick();
      check($sformatf("tx_train_b%0d", i), {28'h0, lane_out}, {28'h0, {4{trb[i]}}});
    end
    for (int w = 0; w < 3; w++) begin
      cw = 8'(w);
      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
        lane_in = 4'($urandom);
        if (w == 2 && i == 4) tx_mode = 2'b10;
        tick();
        if (lane_out !== {4{cw[i]}}) bad = 1'b1;
      end
      check($sformatf("tx_ctr_word%0d", w), {31'h0, bad}, 32'h0);
    end
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      lane_in = 4'($urandom);
      if (i == 2) tx_mode = 2'b00;
      tick();
      if (lane_out !== 4'h0) bad = 1'b1;
    end
    check("tx_idle_word", {31'h0, bad}, 32'h0);
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = 4'($urandom);
      lane_in = v;
      tick();
      if (lane_out !== v) bad = 1'b1;
    end
    check("tx_loop_back", {31'h0, bad}, 32'h0);
    check("locked_held", {28'h0, locked}, 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
